n64_poll_controller: RTL and testbench
======================================

Name: n64_poll_controller

Overview:
Sequences one complete N64 joybus poll transaction on the single-wire controller line.
- Transmits the 8-bit poll command 0x01 plus a stop bit.
- Receives the 32-bit controller status word and presents it on a parallel output.
Sits between the debounced button / poll-pulse logic and the open-drain data pad, clocked by FAB_CLK. Replaces the transmit-only request path with a full request/response sequencer, including timeout.

Parameters:
CYCLES_PER_US, 100, clk cycles per microsecond (FAB_CLK = 100 MHz); all bus timing derives from it.
TIMEOUT_US, 100, maximum wait for any expected falling edge during receive, in microseconds.
POLL_PERIOD_US, 16000, auto-poll interval in microseconds (used only with N64_AUTO_POLL_EN).

Ports:
clk  in  1  FAB_CLK fabric clock
rst_n  in  1  asynchronous active-low reset
poll_req  in  1  one-cycle request to start a poll
data_in  in  1  raw controller line level (asynchronous; pulled high externally)
data_oe  out  1  1 = drive line low (open-drain enable); 0 = release
busy  out  1  transaction in progress
valid  out  1  one-cycle pulse when buttons is updated
buttons  out  32  last good status word; first received bit in [31]
timeout_err  out  1  one-cycle pulse on receive timeout

Behaviour:
Reset: async on rst_n low.
- data_oe=0, busy=0, valid=0, timeout_err=0, buttons=0, state=IDLE.
- data_oe releases immediately, even mid-transaction.

Input sync:
- data_in passes through a 2-flop synchronizer (reset value 1) before any use.
- Edge detection uses the synchronized value plus one extra delayed copy.

States: IDLE, TX_LOW, TX_HIGH, TX_STOP, RX_WAIT_FALL, RX_SAMPLE, RX_WAIT_RISE, DONE.
- IDLE: busy=0. poll_req=1 -> TX_LOW next cycle, bit index 7, shift reg = 0x01, busy=1.
- Bit encoding, 4 us cell: '0' = 3 us low + 1 us high; '1' = 1 us low + 3 us high. MSB first.
- TX_LOW: data_oe=1 for 1 us ('1') or 3 us ('0'), then -> TX_HIGH.
- TX_HIGH: data_oe=0 for the remainder of the cell. After bit 0 -> TX_STOP; otherwise next bit -> TX_LOW.
- TX_STOP: data_oe=1 for 1 us, then release; -> RX_WAIT_FALL, timeout counter cleared.
- RX_WAIT_FALL: on synchronized falling edge -> RX_SAMPLE and start the sample timer. If the timeout counter reaches TIMEOUT_US*CYCLES_PER_US -> IDLE with timeout_err pulse; buttons unchanged.
- RX_SAMPLE: 2 us after the fall, shift in the synchronized level (high = 1); -> RX_WAIT_RISE.
- RX_WAIT_RISE: wait for the line to go high, subject to the same timeout. After 32 bits, the next fall is the controller stop bit.
  - Received bits 0..31: -> RX_WAIT_FALL.
  - After bit 32 (stop bit): -> DONE.
- DONE: buttons <= shift reg; valid pulses 1 cycle; -> IDLE.
- poll_req while busy=1: ignored, not queued.
- Timer widths: sized from the parameters via $clog2; no wrap-around possible within legal parameter values.
- Latency, poll_req to data_oe rising: exactly 1 cycle.
- Exactly one transfer of data_oe per bit; never asserted outside TX states.

Optional Feature:
N64_AUTO_POLL_EN
- Defined: an internal free-running counter generates a start request every POLL_PERIOD_US*CYCLES_PER_US cycles, ORed with poll_req. A request that lands while busy is dropped; the counter keeps running.
- Undefined: polls start only from poll_req; counter logic absent.

Test Plan:
- CYCLES_PER_US=4, poll_req pulse, line idle-high model -> data_oe lows of 12,12,12,12,12,12,12,4 cycles at a 16-cycle pitch, then a 4-cycle stop low; busy=1 throughout.
- Controller model answers 32 bits 0x80104000 + stop bit -> buttons=0x80104000, valid high exactly 1 cycle, busy=0 the next cycle.
- No answer after stop bit, TIMEOUT_US=10 -> timeout_err pulse 40 cycles after the stop release; buttons keeps its previous value; valid stays 0.
- Model stops after 16 bits -> timeout_err pulse; buttons unchanged; next poll_req succeeds normally.
- poll_req asserted again during TX -> ignored; exactly 8 command bits + stop bit seen on data_oe.
- rst_n low during TX_LOW -> data_oe=0 in the same cycle; after release, state is IDLE and busy=0.
- N64_AUTO_POLL_EN, POLL_PERIOD_US=500 -> a transaction starts every 2000 cycles with no poll_req.

Source files
------------

// File: rtl/n64_poll_controller.sv
// N64 joybus poll sequencer: sends command 0x01 + stop bit, receives a 32-bit status word.
// Optional: define N64_AUTO_POLL_EN for a free-running poll request every POLL_PERIOD_US.
module n64_poll_controller #(
    parameter int unsigned CYCLES_PER_US  = 100,
    parameter int unsigned TIMEOUT_US     = 100,
    parameter int unsigned POLL_PERIOD_US = 16000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        poll_req,
    input  logic        data_in,
    output logic        data_oe,
    output logic        busy,
    output logic        valid,
    output logic [31:0] buttons,
    output logic        timeout_err
);

    localparam int unsigned TW = $clog2(4 * CYCLES_PER_US + 1);
    localparam int unsigned OW = $clog2(TIMEOUT_US * CYCLES_PER_US + 1);
    localparam logic [TW-1:0] T_1US   = TW'(CYCLES_PER_US - 1);
    localparam logic [TW-1:0] T_2US   = TW'(2 * CYCLES_PER_US - 1);
    localparam logic [TW-1:0] T_3US   = TW'(3 * CYCLES_PER_US - 1);
    localparam logic [OW-1:0] TO_LAST = OW'(TIMEOUT_US * CYCLES_PER_US - 1);

    if (CYCLES_PER_US < 1 || TIMEOUT_US < 1 || POLL_PERIOD_US < 1) begin : g_param_check
        $error("n64_poll_controller: timing parameters must be non-zero");
    end

    typedef enum logic [2:0] {
        IDLE, TX_LOW, TX_HIGH, TX_STOP, RX_WAIT_FALL, RX_SAMPLE, RX_WAIT_RISE, DONE
    } state_t;

    state_t      state;
    logic        sync1, sync2, sync_d;
    logic        fall;
    logic        start;
    logic [TW-1:0] timer;
    logic [TW-1:0] low_last, high_last;
    logic [OW-1:0] to_cnt;
    logic [7:0]  tx_sr;
    logic [2:0]  bit_idx;
    logic [31:0] rx_sr;
    logic [5:0]  rx_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            sync_d <= 1'b1;
        end else begin
            sync1  <= data_in;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign fall = sync_d & ~sync2;

`ifdef N64_AUTO_POLL_EN
    localparam int unsigned PW = $clog2(POLL_PERIOD_US * CYCLES_PER_US + 1);
    localparam logic [PW-1:0] P_LAST = PW'(POLL_PERIOD_US * CYCLES_PER_US - 1);
    logic [PW-1:0] poll_cnt;
    logic          auto_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt <= '0;
            auto_req <= 1'b0;
        end else if (poll_cnt == P_LAST) begin
            poll_cnt <= '0;
            auto_req <= 1'b1;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
            auto_req <= 1'b0;
        end
    end

    assign start = poll_req | auto_req;
`else
    assign start = poll_req;
`endif

    // Current command bit is tx_sr[7]; its low/high split of the 4 us cell.
    always_comb begin
        low_last  = tx_sr[7] ? T_1US : T_3US;
        high_last = tx_sr[7] ? T_3US : T_1US;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            data_oe     <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            timeout_err <= 1'b0;
            buttons     <= '0;
            timer       <= '0;
            to_cnt      <= '0;
            tx_sr       <= '0;
            bit_idx     <= '0;
            rx_sr       <= '0;
            rx_cnt      <= '0;
        end else begin
            valid       <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= TX_LOW;
                        busy    <= 1'b1;
                        data_oe <= 1'b1;
                        tx_sr   <= 8'h01;
                        bit_idx <= 3'd7;
                        timer   <= '0;
                    end
                end
                TX_LOW: begin
                    if (timer == low_last) begin
                        data_oe <= 1'b0;
                        timer   <= '0;
                        state   <= TX_HIGH;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                TX_HIGH: begin
                    if (timer == high_last) begin
                        timer   <= '0;
                        data_oe <= 1'b1;
                        if (bit_idx == 3'd0) begin
                            state <= TX_STOP;
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                            tx_sr   <= {tx_sr[6:0], 1'b0};
                            state   <= TX_LOW;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (timer == T_1US) begin
                        data_oe <= 1'b0;
                        to_cnt  <= '0;
                        rx_cnt  <= '0;
                        state   <= RX_WAIT_FALL;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_WAIT_FALL: begin
                    if (fall) begin
                        timer <= '0;
                        state <= RX_SAMPLE;
                    end else if (to_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RX_SAMPLE: begin
                    if (timer == T_2US) begin
                        // The controller's stop bit (index 32) is timed but not shifted in.
                        if (rx_cnt != 6'd32) begin
                            rx_sr <= {rx_sr[30:0], sync2};
                        end
                        to_cnt <= '0;
                        state  <= RX_WAIT_RISE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_WAIT_RISE: begin
                    if (sync2) begin
                        if (rx_cnt == 6'd32) begin
                            state <= DONE;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                            to_cnt <= '0;
                            state  <= RX_WAIT_FALL;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    buttons <= rx_sr;
                    valid   <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_n64_poll_controller.sv
// Scoreboard bench for n64_poll_controller: random controller replies vs. a transaction-level model.
module tb_n64_poll_controller;

    localparam int unsigned C  = 4;
    localparam int unsigned TO = 10;

    typedef struct {
        bit          is_to;
        logic [31:0] word;
        int          delay;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        poll_req = 1'b0;
    logic        ctrl_drive = 1'b0;
    logic        data_in;
    logic        data_oe, busy, valid, timeout_err;
    logic [31:0] buttons;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          width = 0;
    int          pulses_seen = 0;
    int          rel_cyc = 0;
    bit          prev_valid = 1'b0;
    logic [31:0] last_good = '0;
    int          exp_pulse[$];
    ev_t         exp_ev[$];

    assign data_in = ~(data_oe | ctrl_drive);

    n64_poll_controller #(
        .CYCLES_PER_US (C),
        .TIMEOUT_US    (TO),
        .POLL_PERIOD_US(500)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .poll_req   (poll_req),
        .data_in    (data_in),
        .data_oe    (data_oe),
        .busy       (busy),
        .valid      (valid),
        .buttons    (buttons),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: data_oe pulse widths and output events, sampled on the falling clock edge.
    always @(negedge clk) begin
        ev_t e;
        cyc++;
        if (!rst_n) begin
            width      = 0;
            prev_valid = 1'b0;
        end else begin
            if (data_oe) begin
                width++;
            end else if (width > 0) begin
                if (exp_pulse.size() == 0) flag("unexpected_oe_pulse");
                else check("oe_low_width", 32'(width), 32'(exp_pulse.pop_front()));
                check("busy_during_tx", 32'(busy), 32'd1);
                pulses_seen++;
                rel_cyc = cyc;
                width   = 0;
            end
            if (prev_valid) begin
                check("valid_width", 32'(valid), 32'd0);
                check("busy_after_valid", 32'(busy), 32'd0);
            end
            if (valid || timeout_err) begin
                if (exp_ev.size() == 0) begin
                    flag("unexpected_event");
                end else begin
                    e = exp_ev.pop_front();
                    check("timeout_err", 32'(timeout_err), 32'(e.is_to));
                    check("valid", 32'(valid), 32'(!e.is_to));
                    check("buttons", buttons, e.word);
                    if (e.delay >= 0) check("timeout_latency", 32'(cyc - rel_cyc), 32'(e.delay));
                end
            end
            prev_valid = valid;
        end
    end

    task automatic drive_bit(input bit b);
        ctrl_drive = 1'b1;
        repeat (b ? C : 3 * C) @(negedge clk);
        ctrl_drive = 1'b0;
        repeat (b ? 3 * C : C) @(negedge clk);
    endtask

    task automatic do_poll(input logic [31:0] word, input int nbits, input bit reissue);
        int base;
        int i;
        for (int b = 7; b >= 0; b--) exp_pulse.push_back((8'h01 >> b) & 1 ? C : 3 * C);
        exp_pulse.push_back(C);
        if (nbits == 32) begin
            exp_ev.push_back('{1'b0, word, -1});
            last_good = word;
        end else begin
            exp_ev.push_back('{1'b1, last_good, (nbits == 0) ? int'(TO * C) : -1});
        end
        base = pulses_seen;
        @(negedge clk);
        poll_req = 1'b1;
        check("busy_before_req", 32'(busy), 32'd0);
        @(negedge clk);
        poll_req = 1'b0;
        check("oe_latency", 32'(data_oe), 32'd1);
        check("busy_set", 32'(busy), 32'd1);
        if (reissue) begin
            repeat (20) @(negedge clk);
            poll_req = 1'b1;
            @(negedge clk);
            poll_req = 1'b0;
        end
        for (i = 0; i < 400 && pulses_seen < base + 9; i++) @(negedge clk);
        if (pulses_seen < base + 9) flag("tx_pulse_count");
        repeat (8) @(negedge clk);
        for (int k = 0; k < nbits; k++) drive_bit(word[31-k]);
        if (nbits == 32) begin
            ctrl_drive = 1'b1;
            repeat (C) @(negedge clk);
            ctrl_drive = 1'b0;
        end
        for (i = 0; i < 300 && busy; i++) @(negedge clk);
        if (busy) flag("busy_stuck");
        repeat (40) @(negedge clk);
        check("busy_idle_after", 32'(busy), 32'd0);
        check("tx_pulses_pending", 32'(exp_pulse.size()), 32'd0);
        check("events_pending", 32'(exp_ev.size()), 32'd0);
    endtask

    initial begin
        #1;
        check("rst_data_oe", 32'(data_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_buttons", buttons, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        do_poll(32'h80104000, 32, 1'b0);
        do_poll($urandom, 0, 1'b0);
        do_poll($urandom, 16, 1'b0);
        do_poll(32'hFFFFFFFF, 32, 1'b0);
        do_poll(32'h00000000, 32, 1'b1);
        for (int n = 0; n < 5; n++) do_poll($urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : 32, n[0]);

        // Reset in the middle of the first command bit's low phase.
        @(negedge clk);
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_data_oe", 32'(data_oe), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_buttons", buttons, 32'd0);
        exp_pulse.delete();
        last_good = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_data_oe", 32'(data_oe), 32'd0);
        do_poll(31'h0, 7, 1'b0);
        do_poll($urandom, 32, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        flag("watchdog_expired");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
